fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose : instruction fetch stage; owns the PC, issues one instruction-memory
//           request at a time and fills the IF/ID register for decode.
// Latency : one cycle from imem_ready (with stall low) to the word on if_*;
//           a zero-wait memory sustains one instruction per cycle.
// Backpr. : stall freezes IF/ID and pc; a response that lands during stall is
//           parked in a one-entry skid buffer and fetching pauses (HOLD).
//
// Ports
//   clock, reset              single clock, asynchronous active-high reset
//   stall                     decode is not consuming IF/ID this cycle
//   redirect_valid/_pc        taken branch/jump: flush IF/ID and refetch
//   imem_req/imem_addr        instruction memory request (word aligned)
//   imem_ready/imem_rdata     response for the current imem_addr
//   if_valid/if_pc/if_instr   IF/ID register (if_instr is NOP when invalid)
//   pc                        current fetch PC
//   stall_cycles              saturating count of stalled cycles with a valid IF/ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // IF/ID payload; the instruction output is masked to NOP when invalid
    logic [31:0] if_instr_q;

    // One-entry skid buffer for a response that arrives while decode stalls
    logic        skid_vld;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    // Control strobes decoded from state and inputs
    logic ifid_clear;
    logic ifid_load_mem;
    logic ifid_load_skid;
    logic skid_load;
    logic skid_clear;
    logic pc_inc;
    logic pc_redirect;

    // Redirect targets are forced onto a word boundary
    logic [31:0] redirect_aligned;
    assign redirect_aligned = redirect_pc & ~32'd3;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    // With the old request still outstanding its response
                    // must be swallowed before refetching.
                    state_nxt = imem_ready ? FETCH : DROP;
                end else if (imem_ready && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall) begin
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                // A redirect here only retargets pc; the stale response is
                // still owed by the memory.
                if (!redirect_valid && imem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        imem_req       = (state == FETCH);
        ifid_clear     = 1'b0;
        ifid_load_mem  = 1'b0;
        ifid_load_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        pc_inc         = 1'b0;
        pc_redirect    = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over stall and imem_ready: a clean bubble only.
            ifid_clear  = 1'b1;
            skid_clear  = 1'b1;
            pc_redirect = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready && !stall) begin
                        ifid_load_mem = 1'b1;
                        pc_inc        = 1'b1;
                    end else if (imem_ready && stall) begin
                        skid_load = 1'b1;
                    end else if (!stall) begin
                        // Decode consumed IF/ID but nothing arrived: bubble.
                        ifid_clear = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall && skid_vld) begin
                        ifid_load_skid = 1'b1;
                        skid_clear     = 1'b1;
                        pc_inc         = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= 32'd0;
            if_instr_q <= NOP_INSTR;
            skid_vld   <= 1'b0;
            skid_pc    <= 32'd0;
            skid_instr <= NOP_INSTR;
        end else begin
            if (pc_redirect) begin
                pc <= redirect_aligned;
            end else if (pc_inc) begin
                pc <= pc + 32'd4;
            end

            if (ifid_clear) begin
                if_valid <= 1'b0;
            end else if (ifid_load_mem) begin
                if_valid   <= 1'b1;
                if_pc      <= pc;
                if_instr_q <= imem_rdata;
            end else if (ifid_load_skid) begin
                if_valid   <= 1'b1;
                if_pc      <= skid_pc;
                if_instr_q <= skid_instr;
            end

            if (skid_clear) begin
                skid_vld <= 1'b0;
            end else if (skid_load) begin
                skid_vld   <= 1'b1;
                skid_pc    <= pc;
                skid_instr <= imem_rdata;
            end
        end
    end

    // Stall statistics: only cycles where decode holds a real instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= 16'd0;
        end else if (stall && if_valid && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    assign imem_addr = pc;
    assign if_instr  = if_valid ? if_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : directed self-checking bench for fetch_stage.
// Latency : n/a
// Backpr. : n/a
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] pc;
    logic [15:0] stall_cycles;

    // Memory model controls: gate the zero-wait answer, or force a stray response
    logic ready_gate  = 1'b1;
    logic force_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .pc             (pc),
        .stall_cycles   (stall_cycles)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'd0:   rom_word = 32'h00a0_0093;
            32'd4:   rom_word = 32'h0030_0213;
            32'd8:   rom_word = 32'h0020_81b3;
            32'd12:  rom_word = 32'h4020_8233;
            32'd16:  rom_word = 32'hffb0_8293;
            default: rom_word = {a[15:0], 16'h0ACE};
        endcase
    endfunction

    assign imem_ready = (imem_req & ready_gate) | force_ready;
    assign imem_rdata = force_ready ? 32'hDEAD_BEEF : rom_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT just after the edge that moved it IDLE -> FETCH at RESET_PC
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        ready_gate     = 1'b1;
        force_ready    = 1'b0;
        repeat (2) step();
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] prog [5];
        prog[0] = 32'h00a0_0093;
        prog[1] = 32'h0030_0213;
        prog[2] = 32'h0020_81b3;
        prog[3] = 32'h4020_8233;
        prog[4] = 32'hffb0_8293;

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst if_valid", if_valid, 0);
        chk("rst if_pc", if_pc, 0);
        chk("rst if_instr", if_instr, 32'h13);
        chk("rst pc", pc, 0);
        chk("rst imem_req", imem_req, 0);
        chk("rst imem_addr", imem_addr, 0);
        chk("rst stall_cycles", stall_cycles, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("idle imem_req", imem_req, 0);
        step();
        chk("first req", imem_req, 1);
        chk("first addr", imem_addr, 0);
        chk("first if_valid", if_valid, 0);

        // ---------------- zero-wait streaming ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stream if_valid", if_valid, 1);
            chk("stream if_pc", if_pc, 32'(4 * i));
            chk("stream if_instr", if_instr, prog[i]);
        end

        // ---------------- stall at if_pc=8 ----------------
        do_reset();
        step();
        step();
        step();
        chk("stall pre if_pc", if_pc, 8);
        stall = 1'b1;
        step();
        chk("stall h1 if_pc", if_pc, 8);
        chk("stall h1 if_valid", if_valid, 1);
        chk("stall h1 imem_req", imem_req, 0);
        step();
        chk("stall h2 if_pc", if_pc, 8);
        chk("stall h2 if_instr", if_instr, 32'h0020_81b3);
        stall = 1'b0;
        step();
        chk("stall post if_pc", if_pc, 12);
        chk("stall post if_instr", if_instr, 32'h4020_8233);
        chk("stall count", stall_cycles, 2);
        step();
        chk("stall next if_pc", if_pc, 16);

        // ---------------- wait states at pc=4 ----------------
        do_reset();
        step();
        chk("wait pre if_pc", if_pc, 0);
        ready_gate = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait imem_addr", imem_addr, 4);
            chk("wait imem_req", imem_req, 1);
            chk("wait if_valid", if_valid, 0);
            chk("wait if_instr", if_instr, 32'h13);
        end
        ready_gate = 1'b1;
        step();
        chk("wait done if_valid", if_valid, 1);
        chk("wait done if_pc", if_pc, 4);
        chk("wait done if_instr", if_instr, 32'h0030_0213);

        // ---------------- redirect while waiting -> DROP ----------------
        do_reset();
        step();
        ready_gate     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
        redirect_valid = 1'b0;
        chk("drop if_valid", if_valid, 0);
        chk("drop if_instr", if_instr, 32'h13);
        chk("drop imem_req", imem_req, 0);
        chk("drop pc", pc, 32'h40);
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        ready_gate  = 1'b1;
        chk("drop late if_valid", if_valid, 0);
        chk("drop refetch req", imem_req, 1);
        chk("drop refetch addr", imem_addr, 32'h40);
        step();
        chk("drop new if_pc", if_pc, 32'h40);
        chk("drop new if_instr", if_instr, 32'h0040_0ACE);

        // ---------------- second redirect inside DROP ----------------
        do_reset();
        step();
        ready_gate     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
        redirect_pc = 32'h0000_0087;
        step();
        redirect_valid = 1'b0;
        chk("drop2 pc", pc, 32'h84);
        chk("drop2 imem_req", imem_req, 0);
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        ready_gate  = 1'b1;
        chk("drop2 refetch addr", imem_addr, 32'h84);
        chk("drop2 if_valid", if_valid, 0);
        step();
        chk("drop2 if_pc", if_pc, 32'h84);
        chk("drop2 if_instr", if_instr, 32'h0084_0ACE);

        // ---------------- redirect with imem_ready=1 ----------------
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        step();
        redirect_valid = 1'b0;
        chk("redir rdy if_valid", if_valid, 0);
        chk("redir rdy req", imem_req, 1);
        chk("redir rdy addr", imem_addr, 32'h10);
        step();
        chk("redir rdy if_pc", if_pc, 32'h10);
        chk("redir rdy if_instr", if_instr, 32'hffb0_8293);

        // ---------------- stall counter saturation ----------------
        do_reset();
        step();
        chk("sat pre if_valid", if_valid, 1);
        stall = 1'b1;
        repeat (65534) step();
        chk("sat FFFE", stall_cycles, 16'hFFFE);
        step();
        chk("sat FFFF", stall_cycles, 16'hFFFF);
        repeat (4465) step();
        chk("sat no wrap", stall_cycles, 16'hFFFF);
        chk("sat if_pc held", if_pc, 0);
        chk("sat in HOLD req", imem_req, 0);

        // ---------------- async reset during HOLD ----------------
        reset = 1'b1;
        #1;
        chk("arst if_valid", if_valid, 0);
        chk("arst if_pc", if_pc, 0);
        chk("arst if_instr", if_instr, 32'h13);
        chk("arst pc", pc, 0);
        chk("arst imem_req", imem_req, 0);
        chk("arst imem_addr", imem_addr, 0);
        chk("arst stall_cycles", stall_cycles, 0);
        stall = 1'b0;
        step();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("arst idle req", imem_req, 0);
        step();
        chk("arst first req", imem_req, 1);
        chk("arst first addr", imem_addr, 0);
        step();
        chk("arst first if_pc", if_pc, 0);
        chk("arst first if_instr", if_instr, 32'h00a0_0093);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
